srrc_tx_sched: RTL
==================

Name: srrc_tx_sched

Overview:
- Sequencer for the practical SRRC TX pulse-shaping filter.
- Generates the sample-rate and symbol-rate clock enables and upsamples symbols by SAM_PER_SYM through zero-stuffing.
- Accepts symbols from the upstream mapper with a valid/ready handshake.
- Controls start, underrun and flush of the 121-tap filter delay line, and flags when the filter output is valid.

Parameters:
CLK_PER_SAM, 4, clk cycles per filter sample; legal range 2..256
SAM_PER_SYM, 4, samples per symbol (upsampling factor); legal range 2..16
FLT_TAPS, 121, filter length in samples; sets the flush length
LAT_SAM, 3, filter input-to-output latency in samples; sets out_valid timing
UND_W, 16, underrun counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begin transmission
stop  in  1  pulse; end transmission and flush
sym_data  in  18  signed symbol level from the mapper
sym_valid  in  1  sym_data is available
sym_ready  out  1  symbol accepted this cycle
flt_in  out  18  signed sample to the filter input
sam_clk_en  out  1  filter sample strobe
sym_clk_en  out  1  symbol strobe
out_valid  out  1  filter output carries real data
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse on a missed symbol
underrun_cnt  out  UND_W  saturating count of missed symbols

Behaviour:
- Reset is synchronous and active-high. All outputs, counters and state go to 0 / IDLE on the next clk edge, including when asserted mid-RUN or mid-FLUSH.
- clk_cnt counts 0..CLK_PER_SAM-1 and wraps. It free-runs in every state after reset.
- sam_clk_en = (clk_cnt == CLK_PER_SAM-1). It is a registered single-cycle pulse, always running.
- ph (0..SAM_PER_SYM-1) is the phase of the sample that the next sam_clk_en will capture. It advances, with wrap, on each sam_clk_en.
- sym_clk_en = sam_clk_en && ph == 0.
- Load cycle = (clk_cnt == CLK_PER_SAM-2). flt_in updates only on load cycles, so it is stable when sam_clk_en is high.
- On a load cycle with ph != 0: flt_in <= 0 (zero-stuff).
- On a load cycle with ph == 0:
  - RUN with sym_valid=1: flt_in <= sym_data; sym_ready = 1 for exactly this cycle.
  - RUN with sym_valid=0: flt_in <= 0; underrun pulses; underrun_cnt increments and saturates at all-ones.
  - IDLE or FLUSH: flt_in <= 0; sym_ready stays 0.
- sym_ready is never high outside a RUN load cycle with ph == 0.
- State machine IDLE / RUN / FLUSH:
  - start_pend and stop_pend are sticky flags set by the start and stop pulses.
  - IDLE -> RUN at a ph == 0 load cycle with start_pend set; that same cycle performs the first symbol fetch. start_pend clears.
  - RUN -> FLUSH at a ph == 0 load cycle with stop_pend set; that load feeds zero. stop_pend clears and flush_cnt <= 0.
  - FLUSH: flush_cnt increments on each sam_clk_en. FLUSH -> IDLE on the sam_clk_en where flush_cnt == FLT_TAPS+LAT_SAM-1.
- Pulse priority and ignored pulses:
  - start and stop in the same cycle while IDLE: both are ignored.
  - start while RUN or FLUSH: ignored.
  - stop while IDLE: ignored.
  - stop while start_pend is set (still IDLE): clears start_pend.
- out_valid:
  - Set on the sam_clk_en that completes LAT_SAM samples after RUN entry.
  - Cleared on the FLUSH -> IDLE sam_clk_en.
  - Changes only on sam_clk_en cycles.
- busy = (state != IDLE), registered.
- Widths: flt_in passes sym_data through unmodified (no scaling). flush_cnt width = clog2(FLT_TAPS+LAT_SAM+1).

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, RUN=2'd1, FLUSH=2'd2;
  - the FLT_TAPS default (121);
  - the 18-bit sample width constant used by the filter and mapper.
- One sub-module, srrc_strobe_gen, contains clk_cnt, ph, sam_clk_en, sym_clk_en and the load-cycle indicator. The FSM, handshake and counters stay in the top.

Test Plan:
- Defaults; reset released; no start -> sam_clk_en every 4th clk (clk_cnt=3), sym_clk_en every 16th clk, flt_in=0, busy=0, sym_ready never asserts.
- start with sym_valid=1 and sym_data sequence 0x08000, 0x38000, ... -> each symbol appears on flt_in for exactly one sample followed by three zero samples; one sym_ready pulse per 16 clks; out_valid rises at the 3rd sam_clk_en after RUN entry.
- In RUN, drop sym_valid for two symbol slots -> flt_in=0 for those slots, two underrun pulses, underrun_cnt=2, state stays RUN.
- stop in RUN -> FLUSH entered at the next ph=0 load; exactly 124 sam_clk_en occur in FLUSH with flt_in=0; then IDLE, out_valid=0, busy=0.
- Assert reset mid-FLUSH (flush_cnt=50) -> next cycle state=IDLE, all outputs 0, underrun_cnt=0, clk_cnt restarts from 0.
- start and stop in the same cycle while IDLE -> state stays IDLE. With UND_W=2, force 5 underruns -> underrun_cnt saturates at 3.

Source files
------------

// File: rtl/srrc_tx_sched_pkg.sv
// Shared definitions for the SRRC TX sequencer: FSM encodings and
// sample-path constants common to the mapper and filter.
package srrc_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } tx_state_e;

  localparam int FLT_TAPS_DEF = 121;
  localparam int SAMPLE_W     = 18;

endpackage

// File: rtl/srrc_tx_sched_strobe_gen.sv
// Free-running sample/symbol strobe generator. Also flags the load cycle one
// clock before each sample strobe so the filter input is stable at capture.
module srrc_strobe_gen #(
  parameter int CLK_PER_SAM = 4,
  parameter int SAM_PER_SYM = 4
) (
  input  logic clk,
  input  logic reset,
  output logic sam_clk_en,
  output logic sym_clk_en,
  output logic load,
  output logic load_ph0
);

  localparam int CNT_W = $clog2(CLK_PER_SAM);
  localparam int PH_W  = $clog2(SAM_PER_SYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SAM - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_PER_SAM - 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SAM_PER_SYM - 1);

  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             sam_clk_en_q, sam_clk_en_d;
  logic             sym_clk_en_q, sym_clk_en_d;

  // ph_q holds the phase of the sample the next strobe captures, so it only
  // moves after a strobe has gone by.
  always_comb begin
    clk_cnt_d = (clk_cnt_q == CNT_LAST) ? '0 : clk_cnt_q + 1'b1;
    ph_d      = ph_q;
    if (sam_clk_en_q) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
    sam_clk_en_d = (clk_cnt_d == CNT_LAST);
    sym_clk_en_d = sam_clk_en_d && (ph_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_q    <= '0;
      ph_q         <= '0;
      sam_clk_en_q <= 1'b0;
      sym_clk_en_q <= 1'b0;
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      ph_q         <= ph_d;
      sam_clk_en_q <= sam_clk_en_d;
      sym_clk_en_q <= sym_clk_en_d;
    end
  end

  assign sam_clk_en = sam_clk_en_q;
  assign sym_clk_en = sym_clk_en_q;
  assign load       = (clk_cnt_q == CNT_LOAD);
  assign load_ph0   = load && (ph_q == '0);

endmodule

// File: rtl/srrc_tx_sched.sv
// SRRC TX sequencer: zero-stuffing upsampler with symbol handshake, underrun
// accounting and delay-line flush control for the pulse-shaping filter.
module srrc_tx_sched
  import srrc_tx_sched_pkg::*;
#(
  parameter int CLK_PER_SAM = 4,
  parameter int SAM_PER_SYM = 4,
  parameter int FLT_TAPS    = FLT_TAPS_DEF,
  parameter int LAT_SAM     = 3,
  parameter int UND_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] sym_data,
  input  logic                sym_valid,
  output logic                sym_ready,
  output logic [SAMPLE_W-1:0] flt_in,
  output logic                sam_clk_en,
  output logic                sym_clk_en,
  output logic                out_valid,
  output logic                busy,
  output logic                underrun,
  output logic [UND_W-1:0]    underrun_cnt
);

  localparam int FLUSH_LEN = FLT_TAPS + LAT_SAM;
  localparam int FC_W      = $clog2(FLUSH_LEN + 1);
  localparam int LAT_W     = $clog2(LAT_SAM + 1);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(LAT_SAM - 1);

  tx_state_e           state_q, state_d;
  logic                start_pend_q, start_pend_d;
  logic                stop_pend_q, stop_pend_d;
  logic [SAMPLE_W-1:0] flt_in_q, flt_in_d;
  logic                underrun_q, underrun_d;
  logic [UND_W-1:0]    underrun_cnt_q, underrun_cnt_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                sam_en, sym_en, load, load_ph0, fetch;

  srrc_strobe_gen #(
    .CLK_PER_SAM(CLK_PER_SAM),
    .SAM_PER_SYM(SAM_PER_SYM)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_en),
    .sym_clk_en (sym_en),
    .load       (load),
    .load_ph0   (load_ph0)
  );

  always_comb begin
    state_d        = state_q;
    start_pend_d   = start_pend_q;
    stop_pend_d    = stop_pend_q;
    flt_in_d       = flt_in_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    lat_cnt_d      = lat_cnt_q;
    out_valid_d    = out_valid_q;
    fetch          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          start_pend_d = 1'b1;
        end else if (stop && !start) begin
          start_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      default: ;
    endcase

    // The RUN entry slot fetches its symbol; the FLUSH entry slot feeds zero.
    if (load) begin
      flt_in_d = '0;
      if (load_ph0) begin
        if (state_q == IDLE && start_pend_q) begin
          state_d      = RUN;
          start_pend_d = 1'b0;
          lat_cnt_d    = '0;
          fetch        = 1'b1;
        end else if (state_q == RUN && stop_pend_q) begin
          state_d     = FLUSH;
          stop_pend_d = 1'b0;
          flush_cnt_d = '0;
        end else if (state_q == RUN) begin
          fetch = 1'b1;
        end
      end
      if (fetch && sym_valid) begin
        flt_in_d = sym_data;
      end else if (fetch) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != '1) begin
          underrun_cnt_d = underrun_cnt_q + 1'b1;
        end
      end
    end

    if (sam_en && state_q != IDLE) begin
      if (!out_valid_q) begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          out_valid_d = 1'b1;
        end
      end
      if (state_q == FLUSH) begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      start_pend_q   <= 1'b0;
      stop_pend_q    <= 1'b0;
      flt_in_q       <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      flush_cnt_q    <= '0;
      lat_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_pend_q   <= start_pend_d;
      stop_pend_q    <= stop_pend_d;
      flt_in_q       <= flt_in_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign sym_ready    = fetch && sym_valid;
  assign flt_in       = flt_in_q;
  assign sam_clk_en   = sam_en;
  assign sym_clk_en   = sym_en;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
